// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
//   Transmit half of a simple UART. The bus-side register block writes bytes
//   into a small FIFO. A serializer drains the FIFO and sends each byte as an
//   8N1 frame: start bit, 8 data bits LSB first, stop bit. Each bit lasts
//   BAUD_DIV clock cycles. Frames for queued bytes follow each other with no
//   idle gap between them.
//
// Parameters
//   BAUD_DIV     HCLK cycles per serial bit (2..65535)
//   FIFO_DEPTH   TX FIFO entries (power of two, 2..256)
//
// Ports
//   HCLK          in   clock; all logic runs on the rising edge
//   HRESETn       in   asynchronous active-low reset; aborts any frame in flight
//   tx_en         in   one-cycle write strobe
//   tx_data[7:0]  in   byte to enqueue; sampled when tx_en=1
//   TX_FIFO_FULL  out  FIFO holds FIFO_DEPTH entries; writes are dropped
//   tx_busy       out  serializer active or FIFO non-empty
//   txd           out  serial line, idle high, driven from a flop
// ---------------------------------------------------------------------------
module uart_tx_engine #(
    parameter int BAUD_DIV   = 434,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       tx_en,
    input  logic [7:0] tx_data,
    output logic       TX_FIFO_FULL,
    output logic       tx_busy,
    output logic       txd
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    // Both flags come from the registered count, so a write arriving while
    // full is dropped even if the serializer pops in that same cycle.
    assign TX_FIFO_FULL = (count == DEPTH_CNT);
    assign fifo_empty   = (count == '0);
    assign push         = tx_en && !TX_FIFO_FULL;

    // NOTE: the storage array has no reset; stale entries are unreachable
    // because pointers and count are reset, and skipping it keeps this a RAM.
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------------------------------------------------- serializer
    state_t      state_q;
    state_t      state_d;
    logic [15:0] baud_q;
    logic [15:0] baud_d;
    logic [2:0]  bit_q;
    logic [2:0]  bit_d;
    logic [7:0]  shift_q;
    logic [7:0]  shift_d;
    logic        txd_d;
    logic        baud_last;

    assign baud_last = (baud_q == BAUD_LAST);
    assign tx_busy   = (state_q != IDLE) || !fifo_empty;

    // State register
    // NOTE: flops use non-blocking assignments so every register samples the
    // pre-edge values of the others; combinational blocks use blocking.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (!fifo_empty)               state_d = START;
            START: if (baud_last)                 state_d = DATA;
            DATA:  if (baud_last && bit_q == 3'd7) state_d = STOP;
            STOP:  if (baud_last)                 state_d = fifo_empty ? IDLE : START;
            default:                              state_d = IDLE;
        endcase
    end

    // Output and datapath logic
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        pop     = 1'b0;
        baud_d  = baud_last ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                baud_d = 16'd0;
                bit_d  = 3'd0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                end
            end
            DATA: begin
                if (baud_last) begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                end
            end
            STOP: begin
                // Pop on the last stop cycle so the next start bit follows
                // immediately with no idle gap.
                if (baud_last) begin
                    bit_d = 3'd0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                    end
                end
            end
            default: ;
        endcase

        // The line level is computed for the state being entered and then
        // registered, so txd changes exactly on the bit boundary and has no
        // decode glitches.
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            baud_q  <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            txd     <= 1'b1;
        end else begin
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd     <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
//   Self-checking bench for uart_tx_engine with BAUD_DIV=4, FIFO_DEPTH=4.
//   Single-frame waveforms come from a table of bytes with hand-computed
//   10-symbol frames (bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop).
//   A free-running UART receiver samples mid-bit and collects decoded bytes
//   and frame start cycles for the multi-frame sequences.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

    localparam int BAUD_DIV   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int FRAME      = 10 * BAUD_DIV;

    logic       HCLK    = 1'b0;
    logic       HRESETn = 1'b1;
    logic       tx_en   = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       TX_FIFO_FULL;
    logic       tx_busy;
    logic       txd;

    uart_tx_engine #(
        .BAUD_DIV  (BAUD_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .tx_en       (tx_en),
        .tx_data     (tx_data),
        .TX_FIFO_FULL(TX_FIFO_FULL),
        .tx_busy     (tx_busy),
        .txd         (txd)
    );

    always #5 HCLK = ~HCLK;

    int unsigned cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // ------------------------------------------------------------ checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ------------------------------------------------------- UART monitor
    logic [7:0]  rx_q[$];
    int unsigned start_q[$];
    int          frame_err = 0;
    int          mon_phase = -1;
    int          mon_bit;
    logic [7:0]  mon_sh = 8'h00;

    initial begin : monitor
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                mon_phase = -1;
            end else begin
                if (mon_phase < 0) begin
                    if (txd === 1'b0) begin
                        mon_phase = 0;
                        start_q.push_back(cyc);
                    end
                end else begin
                    mon_phase++;
                end
                if (mon_phase >= 0 && (mon_phase % BAUD_DIV) == BAUD_DIV / 2) begin
                    mon_bit = mon_phase / BAUD_DIV;
                    if (mon_bit == 0) begin
                        if (txd !== 1'b0) frame_err++;
                    end else if (mon_bit <= 8) begin
                        mon_sh[mon_bit-1] = txd;
                    end else begin
                        if (txd !== 1'b1) frame_err++;
                        rx_q.push_back(mon_sh);
                    end
                end
                if (mon_phase == FRAME - 1) mon_phase = -1;
            end
        end
    end

    // ------------------------------------------------------------- helpers
    int unsigned last_push_cyc = 0;
    logic [7:0]  exp_q[$];

    // Called at a falling edge; the write happens on the next rising edge
    // and the task returns at the falling edge after it.
    task automatic push_byte(input logic [7:0] d);
        tx_en   = 1'b1;
        tx_data = d;
        @(negedge HCLK);
        last_push_cyc = cyc;
        tx_en = 1'b0;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        start_q.delete();
        exp_q.delete();
        frame_err = 0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (tx_busy !== 1'b0 && k < 2000) begin
            @(negedge HCLK);
            k++;
        end
        check(name, tx_busy, 1'b0);
    endtask

    task automatic wait_until(input int unsigned target);
        int k = 0;
        while (cyc < target && k < 2000) begin
            @(negedge HCLK);
            k++;
        end
        check("wait_until_reached", cyc, target);
    endtask

    task automatic check_rx(input string name);
        check({name, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", name, i), rx_q[i], exp_q[i]);
        check({name, "_framing"}, frame_err, 0);
    endtask

    // ------------------------------------------------------------- vectors
    typedef struct {
        string      name;
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    initial begin : stimulus
        int zero_cnt;
        int unsigned p;

        vecs[0] = '{name: "byte_a5", data: 8'hA5, frame: 10'h34A};
        vecs[1] = '{name: "byte_00", data: 8'h00, frame: 10'h200};
        vecs[2] = '{name: "byte_ff", data: 8'hFF, frame: 10'h3FE};
        vecs[3] = '{name: "byte_5a", data: 8'h5A, frame: 10'h2B4};
        vecs[4] = '{name: "byte_80", data: 8'h80, frame: 10'h300};

        // ---- reset state
        #2 HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        check("rst_txd", txd, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_full", TX_FIFO_FULL, 1'b0);
        #2 HRESETn = 1'b1;
        zero_cnt = 0;
        repeat (10) begin
            @(negedge HCLK);
            if (txd !== 1'b1) zero_cnt++;
        end
        check("post_rst_quiet_txd", zero_cnt, 0);
        check("post_rst_quiet_busy", tx_busy, 1'b0);

        // ---- single-frame table: exact cycle-by-cycle waveform
        foreach (vecs[v]) begin
            clear_mon();
            check({vecs[v].name, "_pre_txd"}, txd, 1'b1);
            push_byte(vecs[v].data);
            check({vecs[v].name, "_n_txd"}, txd, 1'b1);
            check({vecs[v].name, "_n_busy"}, tx_busy, 1'b1);
            for (int k = 1; k <= FRAME; k++) begin
                @(negedge HCLK);
                check($sformatf("%s_sym%0d_cyc%0d", vecs[v].name, (k - 1) / BAUD_DIV, k),
                      txd, vecs[v].frame[(k - 1) / BAUD_DIV]);
            end
            check({vecs[v].name, "_busy_last"}, tx_busy, 1'b1);
            @(negedge HCLK);
            check({vecs[v].name, "_busy_done"}, tx_busy, 1'b0);
            check({vecs[v].name, "_txd_done"}, txd, 1'b1);
            exp_q.push_back(vecs[v].data);
            check_rx({vecs[v].name, "_rx"});
            repeat (3) @(negedge HCLK);
        end

        // ---- three back-to-back pushes: contiguous frames, order kept
        clear_mon();
        push_byte(8'h01);
        p = last_push_cyc;
        push_byte(8'h02);
        push_byte(8'h03);
        wait_idle("b2b_idle");
        exp_q = '{8'h01, 8'h02, 8'h03};
        check_rx("b2b_rx");
        check("b2b_starts", start_q.size(), 3);
        if (start_q.size() == 3) begin
            check("b2b_first_start", start_q[0], p + 1);
            check("b2b_gap01", start_q[1] - start_q[0], FRAME);
            check("b2b_gap12", start_q[2] - start_q[1], FRAME);
        end

        // ---- overflow while serializer busy: excess writes dropped
        repeat (3) @(negedge HCLK);
        clear_mon();
        push_byte(8'h11);
        repeat (2) @(negedge HCLK);
        for (int i = 0; i < 6; i++) begin
            push_byte(8'h21 + 8'(i));
            check($sformatf("ovf_full_after_push%0d", i), TX_FIFO_FULL, (i >= 3) ? 1'b1 : 1'b0);
        end
        wait_idle("ovf_idle");
        exp_q = '{8'h11, 8'h21, 8'h22, 8'h23, 8'h24};
        check_rx("ovf_rx");

        // ---- push to full FIFO on the cycle the stop bit ends (pop)
        repeat (3) @(negedge HCLK);
        clear_mon();
        push_byte(8'h31);
        p = last_push_cyc;
        repeat (2) @(negedge HCLK);
        for (int i = 0; i < 4; i++) push_byte(8'h32 + 8'(i));
        check("popfull_full_before", TX_FIFO_FULL, 1'b1);
        wait_until(p + FRAME);
        check("popfull_stop_txd", txd, 1'b1);
        push_byte(8'h36);
        check("popfull_full_after", TX_FIFO_FULL, 1'b0);
        check("popfull_next_start", txd, 1'b0);
        check("popfull_busy", tx_busy, 1'b1);
        wait_idle("popfull_idle");
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
        check_rx("popfull_rx");
        if (start_q.size() >= 2)
            check("popfull_contig", start_q[1] - start_q[0], FRAME);

        // ---- reset during DATA bit 3 of 0x5A with two bytes queued
        repeat (3) @(negedge HCLK);
        clear_mon();
        push_byte(8'h5A);
        p = last_push_cyc;
        push_byte(8'h61);
        push_byte(8'h62);
        wait_until(p + 18);
        check("rstmid_bit3_txd", txd, 1'b1);
        check("rstmid_busy_before", tx_busy, 1'b1);
        #2 HRESETn = 1'b0;
        #1;
        check("rstmid_async_txd", txd, 1'b1);
        check("rstmid_async_busy", tx_busy, 1'b0);
        check("rstmid_async_full", TX_FIFO_FULL, 1'b0);
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        clear_mon();
        zero_cnt = 0;
        repeat (60) begin
            @(negedge HCLK);
            if (txd !== 1'b1) zero_cnt++;
        end
        check("rstmid_no_tx_after", zero_cnt, 0);
        check("rstmid_busy_after", tx_busy, 1'b0);
        check("rstmid_rx_empty", rx_q.size(), 0);

        // ---- reset while the start bit is low: line returns high at once
        push_byte(8'h77);
        @(negedge HCLK);
        check("rststart_low", txd, 1'b0);
        #2 HRESETn = 1'b0;
        #1;
        check("rststart_async_txd", txd, 1'b1);
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        repeat (50) @(negedge HCLK);
        check("rststart_busy_after", tx_busy, 1'b0);

        // ---- ten bytes with flow control: pointer wrap, order preserved
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            int k = 0;
            while (TX_FIFO_FULL && k < 1000) begin
                @(negedge HCLK);
                k++;
            end
            push_byte(8'h3C ^ 8'(i * 17));
            exp_q.push_back(8'h3C ^ 8'(i * 17));
        end
        wait_idle("wrap_idle");
        check_rx("wrap_rx");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 Parameter BAUD_DIV, default 434, HCLK cycles per serial bit (legal range 2..65535).
REQ-002 Parameter FIFO_DEPTH, default 16, TX FIFO entries (power of two, 2..256).
REQ-003 HCLK  input  1  clock; all logic on rising edge.
REQ-004 HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 tx_en  input  1  one-cycle write strobe from bus-side UART slave.
REQ-006 tx_data  input  8  byte to enqueue, sampled when tx_en=1.
REQ-007 TX_FIFO_FULL  output  1  FIFO holds FIFO_DEPTH entries.
REQ-008 tx_busy  output  1  serializer not IDLE or FIFO non-empty.
REQ-009 txd  output  1  serial line, 8N1, idle high.

Function
REQ-010 Push: tx_en=1 and TX_FIFO_FULL=0 at a rising edge SHALL write tx_data at the write pointer and increment it (mod FIFO_DEPTH).
REQ-011 tx_en=1 while TX_FIFO_FULL=1 SHALL be dropped with no state change; no error is flagged.
REQ-012 Occupancy count is log2(FIFO_DEPTH)+1 bits; TX_FIFO_FULL and empty SHALL be decoded from the registered count (full: count==FIFO_DEPTH; empty: count==0).
REQ-013 Simultaneous push and pop SHALL leave count unchanged; the full check uses the pre-edge count, so a push to a full FIFO is dropped even if a pop occurs in the same cycle.
REQ-014 Serializer states: IDLE, START, DATA, STOP.
REQ-015 IDLE: txd=1; if FIFO non-empty at a rising edge, pop head into shift register, clear baud counter and bit index, enter START.
REQ-016 START: txd=0 for exactly BAUD_DIV cycles, then DATA.
REQ-017 DATA: txd=shift[0]; each bit lasts exactly BAUD_DIV cycles; LSB first; after bit 7, enter STOP.
REQ-018 STOP: txd=1 for exactly BAUD_DIV cycles; at the end, if FIFO non-empty, pop and enter START directly (no idle gap), else IDLE.
REQ-019 Baud counter counts 0..BAUD_DIV-1 and wraps; bit advance occurs on the cycle the counter equals BAUD_DIV-1.
REQ-020 txd SHALL be driven from a register (no combinational glitches).
REQ-021 Latency: byte pushed at edge N into empty FIFO with serializer IDLE -> pop at edge N+1, txd low from edge N+1 through N+1+BAUD_DIV.
REQ-022 Frame length SHALL be exactly 10*BAUD_DIV cycles; back-to-back frames SHALL be contiguous.
REQ-023 Bytes SHALL be transmitted in push order; pointers wrap without loss at FIFO_DEPTH.

Reset
REQ-024 HRESETn low SHALL asynchronously force: state IDLE, txd=1, pointers/count 0, TX_FIFO_FULL=0, tx_busy=0, baud counter and bit index 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately (txd=1) and discard all FIFO contents; FIFO RAM need not be cleared.
REQ-026 After reset release, no transmission until a new push.

Verification (BAUD_DIV=4, FIFO_DEPTH=4 unless stated)
REQ-027 Single byte 0xA5 pushed into idle block -> txd sequence 0,1,0,1,0,0,1,0,1,1 per bit, each 4 cycles, start bit begins 1 cycle after push, tx_busy=0 after 40 cycles.
REQ-028 Push 0x01,0x02,0x03 on consecutive cycles -> three contiguous 40-cycle frames, no high gap between STOP and next START, order preserved.
REQ-029 Push 6 bytes back-to-back while serializer busy -> TX_FIFO_FULL asserts once 4 entries are held, excess pushes dropped, exactly the accepted bytes transmitted.
REQ-030 Push to full FIFO in the same cycle STOP ends (pop) -> push dropped, count drops to 3, TX_FIFO_FULL deasserts next cycle.
REQ-031 Assert HRESETn low during DATA bit 3 of 0x5A with 2 bytes queued -> txd=1 immediately, no further frames after release, tx_busy=0.
REQ-032 Push 10 bytes with FIFO_DEPTH=4, pushing only when TX_FIFO_FULL=0 -> pointer wrap exercised, all 10 bytes received in order by a bench UART monitor.
